// File: rtl/code_loader_pkg.sv
// Shared types and default constants for the code-memory loader.
package code_loader_pkg;

  localparam int          CODE_WORDS_DEF = 512;
  localparam int          ADDR_W_DEF     = 9;
  localparam logic [7:0]  SYNC_BYTE_DEF  = 8'hA5;

  typedef enum logic [2:0] {
    IDLE,
    LEN_LO,
    LEN_HI,
    DATA,
    CSUM,
    DONE,
    ERROR
  } state_t;

endpackage

// File: rtl/code_loader_if.sv
// Byte-stream input and code-memory write port; master = loader side.
interface code_loader_if
  import code_loader_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF
) ();

  logic [7:0]        in_data;
  logic              in_valid;
  logic              in_ready;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wd;

  modport master (
    input  in_data, in_valid,
    output in_ready, mem_we, mem_addr, mem_wd
  );

  modport slave (
    output in_data, in_valid,
    input  in_ready, mem_we, mem_addr, mem_wd
  );

endinterface

// File: rtl/code_loader_word_assembler.sv
// Little-endian byte-to-word packer; word_vld_o pulses the cycle after the 4th byte.
module code_loader_word_assembler (
  input  logic        clk,
  input  logic        reset,
  input  logic        clr_i,
  input  logic        byte_vld_i,
  input  logic [7:0]  byte_i,
  output logic        word_end_o,
  output logic        word_vld_o,
  output logic [31:0] word_o
);

  logic [1:0]  idx_q, idx_d;
  logic [23:0] shreg_q, shreg_d;
  logic [31:0] word_q, word_d;
  logic        word_vld_q;

  assign word_end_o = byte_vld_i && (idx_q == 2'd3);
  assign word_vld_o = word_vld_q;
  assign word_o     = word_q;

  // Earlier bytes enter at the top and slide down, so byte 0 ends up in [7:0].
  always_comb begin
    idx_d   = idx_q;
    shreg_d = shreg_q;
    word_d  = word_q;
    if (clr_i) begin
      idx_d = 2'd0;
    end else if (byte_vld_i) begin
      idx_d   = idx_q + 2'd1;
      shreg_d = {byte_i, shreg_q[23:8]};
      if (word_end_o) word_d = {byte_i, shreg_q};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      idx_q      <= 2'd0;
      shreg_q    <= 24'd0;
      word_q     <= 32'd0;
      word_vld_q <= 1'b0;
    end else begin
      idx_q      <= idx_d;
      shreg_q    <= shreg_d;
      word_q     <= word_d;
      word_vld_q <= word_end_o;
    end
  end

endmodule

// File: rtl/code_loader.sv
// Framed byte-stream loader: sync, 16-bit word count, payload, mod-256 checksum.
// Holds the CPU in reset until a complete frame with a good checksum is written.
module code_loader
  import code_loader_pkg::*;
#(
  parameter int         CODE_WORDS = CODE_WORDS_DEF,
  parameter int         ADDR_W     = ADDR_W_DEF,
  parameter logic [7:0] SYNC_BYTE  = SYNC_BYTE_DEF
) (
  input  logic              clk,
  input  logic              reset,
  code_loader_if.master     bus,
  output logic              cpu_hold,
  output logic              load_done,
  output logic              load_err,
  output logic [ADDR_W:0]   words_loaded
);

  state_t            state_q, state_d;
  logic [15:0]       len_q, len_d;
  logic [7:0]        sum_q, sum_d;
  logic [ADDR_W:0]   cnt_q, cnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              last_q, last_d;
  logic              hold_q, hold_d;
  logic              err_q, err_d;

  logic        acc, asm_vld, asm_clr, word_end, word_vld;
  logic [31:0] word;
  logic [15:0] len_full;

  assign acc      = bus.in_valid && bus.in_ready;
  assign asm_vld  = acc && (state_q == DATA) && !last_q;
  assign asm_clr  = acc && (bus.in_data == SYNC_BYTE) && ((state_q == IDLE) || (state_q == ERROR));
  assign len_full = {bus.in_data, len_q[7:0]};

  code_loader_word_assembler u_asm (
    .clk        (clk),
    .reset      (reset),
    .clr_i      (asm_clr),
    .byte_vld_i (asm_vld),
    .byte_i     (bus.in_data),
    .word_end_o (word_end),
    .word_vld_o (word_vld),
    .word_o     (word)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      len_q   <= 16'd0;
      sum_q   <= 8'd0;
      cnt_q   <= '0;
      addr_q  <= '0;
      last_q  <= 1'b0;
      hold_q  <= 1'b1;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      sum_q   <= sum_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      last_q  <= last_d;
      hold_q  <= hold_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    sum_d   = sum_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    last_d  = last_q;
    hold_d  = hold_q;
    err_d   = err_q;
    if (word_vld) cnt_d = cnt_q + {{ADDR_W{1'b0}}, 1'b1};
    unique case (state_q)
      IDLE, ERROR: begin
        if (asm_clr) begin
          state_d = LEN_LO;
          hold_d  = 1'b1;
          err_d   = 1'b0;
          cnt_d   = '0;
          sum_d   = 8'd0;
        end
      end
      LEN_LO: begin
        if (acc) begin
          len_d[7:0] = bus.in_data;
          state_d    = LEN_HI;
        end
      end
      LEN_HI: begin
        if (acc) begin
          len_d[15:8] = bus.in_data;
          last_d      = 1'b0;
          if (len_full > 16'(CODE_WORDS)) begin
            state_d = ERROR;
            err_d   = 1'b1;
          end else if (len_full == 16'd0) begin
            state_d = CSUM;
          end else begin
            state_d = DATA;
          end
        end
      end
      DATA: begin
        // The final word is written while still in DATA; a byte arriving in
        // that same cycle is already the checksum.
        if (last_q) begin
          if (acc) begin
            if (bus.in_data == sum_q) begin
              state_d = DONE;
              hold_d  = 1'b0;
            end else begin
              state_d = ERROR;
              err_d   = 1'b1;
            end
          end else begin
            state_d = CSUM;
          end
        end else if (asm_vld) begin
          sum_d = sum_q + bus.in_data;
          if (word_end) begin
            addr_d = cnt_q[ADDR_W-1:0];
            if (16'(cnt_q) + 16'd1 == len_q) last_d = 1'b1;
          end
        end
      end
      CSUM: begin
        if (acc) begin
          if (bus.in_data == sum_q) begin
            state_d = DONE;
            hold_d  = 1'b0;
          end else begin
            state_d = ERROR;
            err_d   = 1'b1;
          end
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign bus.in_ready  = (state_q != DONE);
  assign bus.mem_we    = word_vld;
  assign bus.mem_addr  = addr_q;
  assign bus.mem_wd    = word;
  assign cpu_hold      = hold_q;
  assign load_done     = (state_q == DONE);
  assign load_err      = err_q;
  assign words_loaded  = cnt_q;

endmodule

// File: tb/tb_code_loader.sv
module tb_code_loader;
  import code_loader_pkg::*;

  logic       clk;
  logic       rst;
  logic       cpu_hold, load_done, load_err;
  logic [9:0] words_loaded;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int last_acc = 0;
  int c4       = 0;

  logic [8:0]  wr_addr[$];
  logic [31:0] wr_dat[$];
  int          wr_cyc[$];
  int          done_cnt  = 0;
  logic        done_hold = 1'b1;
  logic        done_rdy  = 1'b1;

  code_loader_if #(.ADDR_W(9)) ifc ();

  code_loader dut (
    .clk          (clk),
    .reset        (rst),
    .bus          (ifc),
    .cpu_hold     (cpu_hold),
    .load_done    (load_done),
    .load_err     (load_err),
    .words_loaded (words_loaded)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (ifc.mem_we) begin
      wr_addr.push_back(ifc.mem_addr);
      wr_dat.push_back(ifc.mem_wd);
      wr_cyc.push_back(cyc);
    end
    if (load_done) begin
      done_cnt  = done_cnt + 1;
      done_hold = cpu_hold;
      done_rdy  = ifc.in_ready;
    end
  end

  task automatic clear_log();
    wr_addr.delete();
    wr_dat.delete();
    wr_cyc.delete();
    done_cnt  = 0;
    done_hold = 1'b1;
    done_rdy  = 1'b1;
  endtask

  task automatic send(input logic [7:0] b);
    int t;
    t = 0;
    @(negedge clk);
    ifc.in_data  = b;
    ifc.in_valid = 1'b1;
    while (!ifc.in_ready && t < 16) begin
      @(negedge clk);
      t++;
    end
    if (!ifc.in_ready) begin
      n_checks++;
      n_fail++;
      $display("FAIL send_timeout: in_ready=%b required 1", ifc.in_ready);
    end
    last_acc = cyc;
  endtask

  task automatic idle(input int n);
    @(negedge clk);
    ifc.in_valid = 1'b0;
    repeat (n - 1) @(negedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    ifc.in_valid = 1'b0;
    ifc.in_data  = 8'h00;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    n_checks++; if (ifc.in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b required 1", ifc.in_ready); end
    n_checks++; if (ifc.mem_we !== 1'b0) begin n_fail++; $display("FAIL reset_mem_we: got %b required 0", ifc.mem_we); end
    n_checks++; if (ifc.mem_addr !== 9'd0) begin n_fail++; $display("FAIL reset_mem_addr: got %h required 0", ifc.mem_addr); end
    n_checks++; if (ifc.mem_wd !== 32'd0) begin n_fail++; $display("FAIL reset_mem_wd: got %h required 0", ifc.mem_wd); end
    n_checks++; if (cpu_hold !== 1'b1) begin n_fail++; $display("FAIL reset_cpu_hold: got %b required 1", cpu_hold); end
    n_checks++; if (load_done !== 1'b0) begin n_fail++; $display("FAIL reset_load_done: got %b required 0", load_done); end
    n_checks++; if (load_err !== 1'b0) begin n_fail++; $display("FAIL reset_load_err: got %b required 0", load_err); end
    n_checks++; if (words_loaded !== 10'd0) begin n_fail++; $display("FAIL reset_words: got %0d required 0", words_loaded); end
    n_checks++; if (dut.state_q !== IDLE) begin n_fail++; $display("FAIL reset_state: got %0d required IDLE", dut.state_q); end
  endtask

  // Payload 01 00 40 E2 -> word E2400001, checksum 0x01+0x00+0x40+0xE2 = 0x23.
  task automatic test_single_word();
    clear_log();
    send(8'hA5); send(8'h01); send(8'h00);
    send(8'h01); send(8'h00); send(8'h40); send(8'hE2);
    c4 = last_acc;
    send(8'h23);
    idle(4);
    n_checks++; if (wr_cyc.size() !== 1) begin n_fail++; $display("FAIL single_write_count: got %0d required 1", wr_cyc.size()); end
    if (wr_cyc.size() >= 1) begin
      n_checks++; if (wr_addr[0] !== 9'd0) begin n_fail++; $display("FAIL single_addr: got %h required 0", wr_addr[0]); end
      n_checks++; if (wr_dat[0] !== 32'hE2400001) begin n_fail++; $display("FAIL single_wd: got %h required E2400001", wr_dat[0]); end
      n_checks++; if (wr_cyc[0] !== c4 + 1) begin n_fail++; $display("FAIL single_latency: got cycle %0d required %0d", wr_cyc[0], c4 + 1); end
    end
    n_checks++; if (done_cnt !== 1) begin n_fail++; $display("FAIL single_done_count: got %0d required 1", done_cnt); end
    n_checks++; if (done_hold !== 1'b0) begin n_fail++; $display("FAIL single_hold_at_done: got %b required 0", done_hold); end
    n_checks++; if (done_rdy !== 1'b0) begin n_fail++; $display("FAIL single_ready_at_done: got %b required 0", done_rdy); end
    n_checks++; if (cpu_hold !== 1'b0) begin n_fail++; $display("FAIL single_cpu_hold: got %b required 0", cpu_hold); end
    n_checks++; if (words_loaded !== 10'd1) begin n_fail++; $display("FAIL single_words: got %0d required 1", words_loaded); end
    n_checks++; if (load_err !== 1'b0) begin n_fail++; $display("FAIL single_err: got %b required 0", load_err); end
  endtask

  // Payload 11..88: words 44332211, 88776655; sum wraps to 0x64.
  task automatic send_two_word(input logic [7:0] csum);
    send(8'hA5); send(8'h02); send(8'h00);
    send(8'h11); send(8'h22); send(8'h33); send(8'h44);
    send(8'h55); send(8'h66); send(8'h77); send(8'h88);
    c4 = last_acc;
    send(csum);
    idle(4);
  endtask

  task automatic test_back_to_back();
    clear_log();
    send_two_word(8'h64);
    n_checks++; if (wr_cyc.size() !== 2) begin n_fail++; $display("FAIL b2b_write_count: got %0d required 2", wr_cyc.size()); end
    if (wr_cyc.size() == 2) begin
      n_checks++; if (wr_addr[0] !== 9'd0 || wr_addr[1] !== 9'd1) begin n_fail++; $display("FAIL b2b_addr: got %h,%h required 0,1", wr_addr[0], wr_addr[1]); end
      n_checks++; if (wr_dat[0] !== 32'h44332211) begin n_fail++; $display("FAIL b2b_wd0: got %h required 44332211", wr_dat[0]); end
      n_checks++; if (wr_dat[1] !== 32'h88776655) begin n_fail++; $display("FAIL b2b_wd1: got %h required 88776655", wr_dat[1]); end
      n_checks++; if (wr_cyc[1] - wr_cyc[0] !== 4) begin n_fail++; $display("FAIL b2b_spacing: got %0d required 4", wr_cyc[1] - wr_cyc[0]); end
      n_checks++; if (wr_cyc[1] !== c4 + 1) begin n_fail++; $display("FAIL b2b_latency: got cycle %0d required %0d", wr_cyc[1], c4 + 1); end
    end
    n_checks++; if (done_cnt !== 1) begin n_fail++; $display("FAIL b2b_done_count: got %0d required 1", done_cnt); end
    n_checks++; if (words_loaded !== 10'd2) begin n_fail++; $display("FAIL b2b_words: got %0d required 2", words_loaded); end
    n_checks++; if (cpu_hold !== 1'b0) begin n_fail++; $display("FAIL b2b_cpu_hold: got %b required 0", cpu_hold); end
  endtask

  task automatic test_bad_csum();
    clear_log();
    send_two_word(8'h65);
    n_checks++; if (load_err !== 1'b1) begin n_fail++; $display("FAIL badsum_err: got %b required 1", load_err); end
    n_checks++; if (cpu_hold !== 1'b1) begin n_fail++; $display("FAIL badsum_hold: got %b required 1", cpu_hold); end
    n_checks++; if (done_cnt !== 0) begin n_fail++; $display("FAIL badsum_done: got %0d required 0", done_cnt); end
    n_checks++; if (wr_cyc.size() !== 2) begin n_fail++; $display("FAIL badsum_partial_writes: got %0d required 2", wr_cyc.size()); end
    n_checks++; if (dut.state_q !== ERROR) begin n_fail++; $display("FAIL badsum_state: got %0d required ERROR", dut.state_q); end
    send(8'h5A);
    idle(2);
    n_checks++; if (load_err !== 1'b1) begin n_fail++; $display("FAIL badsum_sticky: got %b required 1", load_err); end
    clear_log();
    send(8'hA5);
    idle(1);
    n_checks++; if (load_err !== 1'b0) begin n_fail++; $display("FAIL badsum_sync_clears: got %b required 0", load_err); end
    send(8'h01); send(8'h00);
    send(8'h01); send(8'h00); send(8'h40); send(8'hE2); send(8'h23);
    idle(4);
    n_checks++; if (done_cnt !== 1) begin n_fail++; $display("FAIL recover_done: got %0d required 1", done_cnt); end
    n_checks++; if (cpu_hold !== 1'b0) begin n_fail++; $display("FAIL recover_hold: got %b required 0", cpu_hold); end
  endtask

  task automatic test_len_too_big();
    clear_log();
    send(8'hA5); send(8'h01); send(8'h02);
    send(8'h00); send(8'h11); send(8'h22); send(8'h33);
    idle(4);
    n_checks++; if (load_err !== 1'b1) begin n_fail++; $display("FAIL biglen_err: got %b required 1", load_err); end
    n_checks++; if (dut.state_q !== ERROR) begin n_fail++; $display("FAIL biglen_state: got %0d required ERROR", dut.state_q); end
    n_checks++; if (wr_cyc.size() !== 0) begin n_fail++; $display("FAIL biglen_writes: got %0d required 0", wr_cyc.size()); end
    n_checks++; if (cpu_hold !== 1'b1) begin n_fail++; $display("FAIL biglen_hold: got %b required 1", cpu_hold); end
  endtask

  task automatic test_zero_len();
    clear_log();
    send(8'hA5); send(8'h00); send(8'h00); send(8'h00);
    idle(4);
    n_checks++; if (done_cnt !== 1) begin n_fail++; $display("FAIL zero_done: got %0d required 1", done_cnt); end
    n_checks++; if (wr_cyc.size() !== 0) begin n_fail++; $display("FAIL zero_writes: got %0d required 0", wr_cyc.size()); end
    n_checks++; if (words_loaded !== 10'd0) begin n_fail++; $display("FAIL zero_words: got %0d required 0", words_loaded); end
    n_checks++; if (load_err !== 1'b0) begin n_fail++; $display("FAIL zero_err: got %b required 0", load_err); end
  endtask

  task automatic test_reset_mid_frame();
    clear_log();
    send(8'hA5); send(8'h01); send(8'h00);
    send(8'hAA); send(8'hBB); send(8'hCC);
    // 4th byte presented while reset is high: it must not produce a write.
    @(negedge clk);
    ifc.in_data  = 8'hDD;
    ifc.in_valid = 1'b1;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    ifc.in_valid = 1'b0;
    #1;
    n_checks++; if (dut.state_q !== IDLE) begin n_fail++; $display("FAIL midrst_state: got %0d required IDLE", dut.state_q); end
    n_checks++; if (cpu_hold !== 1'b1) begin n_fail++; $display("FAIL midrst_hold: got %b required 1", cpu_hold); end
    n_checks++; if (ifc.mem_we !== 1'b0) begin n_fail++; $display("FAIL midrst_mem_we: got %b required 0", ifc.mem_we); end
    send(8'h00); send(8'h12); send(8'hDD); send(8'hE2);
    idle(4);
    n_checks++; if (wr_cyc.size() !== 0) begin n_fail++; $display("FAIL midrst_writes: got %0d required 0", wr_cyc.size()); end
    n_checks++; if (dut.state_q !== IDLE) begin n_fail++; $display("FAIL garbage_state: got %0d required IDLE", dut.state_q); end
    n_checks++; if (words_loaded !== 10'd0) begin n_fail++; $display("FAIL midrst_words: got %0d required 0", words_loaded); end
    send(8'hA5); send(8'h00); send(8'h00); send(8'h00);
    idle(4);
    n_checks++; if (done_cnt !== 1) begin n_fail++; $display("FAIL midrst_recover: got %0d required 1", done_cnt); end
  endtask

  initial begin
    test_reset();
    test_single_word();
    test_back_to_back();
    test_bad_csum();
    test_len_too_big();
    test_zero_len();
    test_reset_mid_frame();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
